// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader: bank-state encoding and the
// default sizing constants used by the top, the skew generator and the bus
// interface.
package weight_loader_pkg;

  localparam int DEF_SYS_ROW    = 16;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/weight_loader_if.sv
// Per-lane data buses of the weight loader.
//   mem_rd_en / mem_rd_addr : read requests to the weight memory
//   mem_rd_data             : memory read data, one cycle after the request
//   w_out / w_wen           : weights pushed into the systolic array
// master = the loader, slave = the memory/array side.
interface weight_loader_if
  import weight_loader_pkg::*;
#(
  parameter int SYS_ROW    = DEF_SYS_ROW,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic [SYS_ROW-1:0]                 mem_rd_en;
  logic [SYS_ROW-1:0][ADDR_WIDTH-1:0] mem_rd_addr;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] mem_rd_data;
  logic [SYS_ROW-1:0][DATA_WIDTH-1:0] w_out;
  logic [SYS_ROW-1:0]                 w_wen;

  modport master (
    output mem_rd_en, mem_rd_addr, w_out, w_wen,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, w_out, w_wen,
    output mem_rd_data
  );

endinterface

// File: rtl/weight_loader_skew_ctrl.sv
// skew_ctrl: diagonal enable/index generator.
// After start, lane 0 is enabled for len consecutive cycles with index
// 0..len-1; lane j repeats lane 0 delayed by j cycles.
//   start    : begin a sequence (len sampled with it)
//   en/idx   : per-lane enable and entry index
//   last_out : high while the final lane presents its final entry
module skew_ctrl
  import weight_loader_pkg::*;
#(
  parameter int  LANES = DEF_SYS_ROW,
  parameter int  DEPTH = DEF_FIFO_DEPTH,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [LW-1:0]            len,
  output logic [LANES-1:0]         en,
  output logic [LANES-1:0][IW-1:0] idx,
  output logic                     last_out
);

  logic [LANES-1:0] last;
  logic [LW-1:0]    remain;   // entries still to come after the current one

  assign last_out = last[LANES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en     <= '0;
      idx    <= '0;
      last   <= '0;
      remain <= '0;
    end else begin
      if (start) begin
        en[0]   <= 1'b1;
        idx[0]  <= '0;
        remain  <= len - LW'(1);
        last[0] <= (len == LW'(1));
      end else if (en[0]) begin
        if (remain == '0) begin
          en[0]   <= 1'b0;
          last[0] <= 1'b0;
        end else begin
          idx[0]  <= idx[0] + IW'(1);
          remain  <= remain - LW'(1);
          last[0] <= (remain == LW'(1));
        end
      end
      for (int j = 1; j < LANES; j++) begin
        en[j]   <= en[j-1];
        idx[j]  <= idx[j-1];
        last[j] <= last[j-1];
      end
    end
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: ping-pong weight buffer between weight memory and a systolic
// array. A fill reads load_len entries per lane with diagonal skew into the
// next bank; a drain replays the oldest full bank, last entry first, with the
// same skew. Fill and drain run concurrently on different banks.
//   clk, rstn                    : clock, async active-low reset
//   load_start/load_base/load_len: fill request
//   drain_start                  : drain request
//   bus                          : memory read bus and array weight bus
//   load_busy/drain_busy         : operation in progress
//   load_done/drain_done         : one-cycle completion pulses
//   full_cnt                     : number of FULL banks
//   err                          : one-cycle pulse on any rejected request
//
// Bank state (one per bank)
//   state    | meaning
//   EMPTY    | free, may be filled
//   FILLING  | receiving memory data
//   FULL     | holds a complete set of weights
//   DRAINING | being replayed into the array
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int SYS_ROW    = DEF_SYS_ROW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             load_start,
  input  logic [ADDR_WIDTH-1:0]            load_base,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]  load_len,
  weight_loader_if.master                  bus,
  input  logic                             drain_start,
  output logic                             load_busy,
  output logic                             drain_busy,
  output logic                             load_done,
  output logic                             drain_done,
  output logic [1:0]                       full_cnt,
  output logic                             err
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  bank_state_t     bank_st [2];
  logic [LW-1:0]   bank_len [2];
  logic            fill_ptr, drain_ptr;
  logic            fill_bank, drain_bank;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]   drain_len_q;

  logic [SYS_ROW-1:0]         fill_en, drain_en, wr_en_d;
  logic [SYS_ROW-1:0][IW-1:0] fill_idx, drain_idx, wr_idx_d;
  logic                       fill_last, drain_last, wr_last_d;

  logic [DATA_WIDTH-1:0] store [2][SYS_ROW][FIFO_DEPTH];

  logic load_ok, drain_ok;

  // The fill pointer only advances on acceptance, and drains follow the same
  // order, so drain_ptr always names the oldest filled bank.
  assign load_ok  = load_start && !load_busy && (bank_st[fill_ptr] == EMPTY) &&
                    (load_len != '0) && (load_len <= LW'(FIFO_DEPTH));
  assign drain_ok = drain_start && !drain_busy && (bank_st[drain_ptr] == FULL);

  assign full_cnt = 2'(bank_st[0] == FULL) + 2'(bank_st[1] == FULL);

  skew_ctrl #(.LANES(SYS_ROW), .DEPTH(FIFO_DEPTH)) u_fill_skew (
    .clk      (clk),
    .rstn     (rstn),
    .start    (load_ok),
    .len      (load_len),
    .en       (fill_en),
    .idx      (fill_idx),
    .last_out (fill_last)
  );

  skew_ctrl #(.LANES(SYS_ROW), .DEPTH(FIFO_DEPTH)) u_drain_skew (
    .clk      (clk),
    .rstn     (rstn),
    .start    (drain_ok),
    .len      (bank_len[drain_ptr]),
    .en       (drain_en),
    .idx      (drain_idx),
    .last_out (drain_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      fill_ptr    <= 1'b0;
      drain_ptr   <= 1'b0;
      fill_bank   <= 1'b0;
      drain_bank  <= 1'b0;
      base_q      <= '0;
      drain_len_q <= '0;
      load_busy   <= 1'b0;
      drain_busy  <= 1'b0;
      load_done   <= 1'b0;
      drain_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      drain_done <= 1'b0;
      err        <= (load_start && !load_ok) || (drain_start && !drain_ok);

      if (load_ok) begin
        bank_st[fill_ptr]  <= FILLING;
        bank_len[fill_ptr] <= load_len;
        fill_bank          <= fill_ptr;
        fill_ptr           <= ~fill_ptr;
        base_q             <= load_base;
        load_busy          <= 1'b1;
      end else if (load_busy && wr_last_d) begin
        // last lane's last word is written at this edge
        bank_st[fill_bank] <= FULL;
        load_busy          <= 1'b0;
        load_done          <= 1'b1;
      end

      if (drain_ok) begin
        bank_st[drain_ptr] <= DRAINING;
        drain_bank         <= drain_ptr;
        drain_ptr          <= ~drain_ptr;
        drain_len_q        <= bank_len[drain_ptr];
        drain_busy         <= 1'b1;
      end else if (drain_busy && drain_last) begin
        bank_st[drain_bank] <= EMPTY;
        drain_busy          <= 1'b0;
        drain_done          <= 1'b1;
      end
    end
  end

  // Read data arrives one cycle after the request; delay enable/index to match.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_d   <= '0;
      wr_idx_d  <= '0;
      wr_last_d <= 1'b0;
    end else begin
      wr_en_d   <= fill_en;
      wr_idx_d  <= fill_idx;
      wr_last_d <= fill_last;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < SYS_ROW; j++) begin
      if (wr_en_d[j]) store[fill_bank][j][wr_idx_d[j]] <= bus.mem_rd_data[j];
    end
  end

  // Drain presents entries in reverse order: index k maps to entry len-1-k.
  always_comb begin
    bus.mem_rd_en   = '0;
    bus.mem_rd_addr = '0;
    bus.w_wen       = '0;
    bus.w_out       = '0;
    for (int j = 0; j < SYS_ROW; j++) begin
      bus.mem_rd_en[j] = fill_en[j];
      bus.w_wen[j]     = drain_en[j];
      if (fill_en[j])
        bus.mem_rd_addr[j] = base_q + ADDR_WIDTH'(fill_idx[j]);
      if (drain_en[j])
        bus.w_out[j] = store[drain_bank][j]
                         [IW'(drain_len_q - LW'(1) - LW'(drain_idx[j]))];
    end
  end

endmodule
